// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue controller: opcode constants,
// FSM state encoding and the opcode-to-wait-class helpers.
package alu_pkg;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_NEG  = 4'd4;
   localparam logic [3:0] OP_NOT  = 4'd5;
   localparam logic [3:0] OP_SHR  = 4'd6;
   localparam logic [3:0] OP_SHRA = 4'd7;
   localparam logic [3:0] OP_SHL  = 4'd8;
   localparam logic [3:0] OP_ROR  = 4'd9;
   localparam logic [3:0] OP_ROL  = 4'd10;
   localparam logic [3:0] OP_MUL  = 4'd11;
   localparam logic [3:0] OP_DIV  = 4'd12;
   localparam logic [3:0] OP_LAST = OP_DIV;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // MUL and DIV need the long settle window; everything else is single-word.
   function automatic logic wait_is_long(input logic [3:0] op);
      return (op == OP_MUL) || (op == OP_DIV);
   endfunction

   function automatic logic op_illegal(input logic [3:0] op);
      return op > OP_LAST;
   endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request/response handshake bundle between the control path (master)
// and the ALU issue controller (slave).
interface alu_issue_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] z_hi;
   logic [31:0] z_lo;
   logic        rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, z_hi, z_lo, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, z_hi, z_lo, rsp_err
   );
endinterface

// File: rtl/alu_issue_timer.sv
// Loadable down-counter timing the ALU settle window; done while at zero.
module alu_issue_timer #(
   parameter int CW = 2
) (
   input  logic          clock,
   input  logic          clear,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   input  logic          dec,
   output logic          done
);
   logic [CW-1:0] cnt;

   // load wins over decrement; counter saturates at zero
   always_ff @(posedge clock) begin
      if (clear)                 cnt <= '0;
      else if (load)             cnt <= load_val;
      else if (dec && cnt != '0) cnt <= cnt - CW'(1);
   end

   assign done = (cnt == '0);
endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one op, holds ALU inputs with exec high for
// the settle window, captures the 64-bit result into z_hi/z_lo and presents
// it on the response port.
// Optional feature macro: ALU_ISSUE_OPCHECK_EN (opcodes 13-15 skip EXEC and
// respond with rsp_err=1, z=0).
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int BASE_WAIT = 1,
   parameter int MUL_WAIT  = 4
) (
   input  logic                clock,
   input  logic                clear,
   alu_issue_ctrl_if.slave     bus,
   output logic [3:0]          alu_opcode,
   output logic                alu_exec,
   output logic [31:0]         alu_operand_A,
   output logic [31:0]         alu_operand_B,
   input  logic [63:0]         alu_result,
   output logic                busy
);
   // zero-length windows are promoted to one cycle
   localparam int BW   = (BASE_WAIT < 1) ? 1 : BASE_WAIT;
   localparam int MW   = (MUL_WAIT  < 1) ? 1 : MUL_WAIT;
   localparam int MAXW = (BW > MW) ? BW : MW;
   localparam int CW   = (MAXW > 1) ? $clog2(MAXW) : 1;
   localparam logic [CW-1:0] BASE_LD = CW'(BW - 1);
   localparam logic [CW-1:0] MUL_LD  = CW'(MW - 1);

   state_e      state;
   logic [3:0]  op_q;
   logic [31:0] a_q, b_q;
   logic [63:0] z_q;
   logic        err_q, ready_q, exec_q, rsp_q, busy_q;
   logic        accept, t_done;
   logic [CW-1:0] ld_val;

   assign accept = ready_q && bus.req_valid;
   assign ld_val = wait_is_long(bus.req_op) ? MUL_LD : BASE_LD;

   alu_issue_timer #(.CW(CW)) u_timer (
      .clock    (clock),
      .clear    (clear),
      .load     (accept),
      .load_val (ld_val),
      .dec      (exec_q),
      .done     (t_done)
   );

   // issue FSM with all handshake/ALU controls registered alongside the state
   always_ff @(posedge clock) begin
      if (clear) begin
         state   <= ST_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         z_q     <= '0;
         err_q   <= 1'b0;
         ready_q <= 1'b1;
         exec_q  <= 1'b0;
         rsp_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (accept) begin
               op_q    <= bus.req_op;
               a_q     <= bus.req_a;
               b_q     <= bus.req_b;
               ready_q <= 1'b0;
               busy_q  <= 1'b1;
`ifdef ALU_ISSUE_OPCHECK_EN
               if (op_illegal(bus.req_op)) begin
                  z_q   <= '0;
                  err_q <= 1'b1;
                  rsp_q <= 1'b1;
                  state <= ST_RESP;
               end else begin
                  exec_q <= 1'b1;
                  state  <= ST_EXEC;
               end
`else
               exec_q <= 1'b1;
               state  <= ST_EXEC;
`endif
            end
            ST_EXEC: if (t_done) begin
               z_q    <= alu_result;
               err_q  <= 1'b0;
               exec_q <= 1'b0;
               rsp_q  <= 1'b1;
               state  <= ST_RESP;
            end
            ST_RESP: if (bus.rsp_ready) begin
               rsp_q   <= 1'b0;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               state   <= ST_IDLE;
            end
            default: begin
               exec_q  <= 1'b0;
               rsp_q   <= 1'b0;
               ready_q <= 1'b1;
               busy_q  <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready  = ready_q;
   assign bus.rsp_valid  = rsp_q;
   assign bus.z_hi       = z_q[63:32];
   assign bus.z_lo       = z_q[31:0];
   assign bus.rsp_err    = err_q;
   assign alu_opcode     = op_q;
   assign alu_operand_A  = a_q;
   assign alu_operand_B  = b_q;
   assign alu_exec       = exec_q;
   assign busy           = busy_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: vector table plus hand-written
// backpressure, mid-op clear and illegal-opcode sequences.
module tb_alu_issue_ctrl;
   logic        clk = 1'b0;
   logic        clear;
   logic [3:0]  alu_opcode;
   logic        alu_exec;
   logic [31:0] alu_operand_A, alu_operand_B;
   logic [63:0] alu_result;
   logic        busy;
   int          pass_cnt = 0;
   int          total = 0;

   alu_issue_ctrl_if bif ();

   alu_issue_ctrl #(.BASE_WAIT(1), .MUL_WAIT(4)) dut (
      .clock         (clk),
      .clear         (clear),
      .bus           (bif),
      .alu_opcode    (alu_opcode),
      .alu_exec      (alu_exec),
      .alu_operand_A (alu_operand_A),
      .alu_operand_B (alu_operand_B),
      .alu_result    (alu_result),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // behavioural ALU: single-word ops zero the upper half, MUL signed 64-bit,
   // DIV gives {remainder, quotient}, unknown opcodes return {a, b}
   function automatic logic [63:0] alu_model(input logic [3:0] op, input logic [31:0] a, b);
      logic [63:0] r;
      r = {a, b};
      case (op)
         4'd0:  r = {32'h0, a + b};
         4'd1:  r = {32'h0, a - b};
         4'd2:  r = {32'h0, a & b};
         4'd3:  r = {32'h0, a | b};
         4'd4:  r = {32'h0, -a};
         4'd5:  r = {32'h0, ~a};
         4'd6:  r = {32'h0, a >> b[4:0]};
         4'd7:  r = {32'h0, $unsigned($signed(a) >>> b[4:0])};
         4'd8:  r = {32'h0, a << b[4:0]};
         4'd9:  r = {32'h0, (a >> b[4:0]) | (a << (6'd32 - {1'b0, b[4:0]}))};
         4'd10: r = {32'h0, (a << b[4:0]) | (a >> (6'd32 - {1'b0, b[4:0]}))};
         4'd11: r = $unsigned($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
         4'd12: r = (b == 0) ? 64'h0 : {$unsigned($signed(a) % $signed(b)), $unsigned($signed(a) / $signed(b))};
         default: r = {a, b};
      endcase
      return r;
   endfunction

   assign alu_result = alu_model(alu_opcode, alu_operand_A, alu_operand_B);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // issue one op with rsp_ready already high; report result and timing
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic err,
                         output int nexec, output int lat, output logic stable, output logic pulse1);
      int g;
      @(negedge clk);
      bif.req_valid = 1'b1; bif.req_op = op; bif.req_a = a; bif.req_b = b;
      g = 0;
      while (!bif.req_ready && g < 20) begin @(negedge clk); g++; end
      @(posedge clk); #1 bif.req_valid = 1'b0;
      nexec = 0; lat = -1; stable = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (bif.rsp_valid) begin lat = c; break; end
         if (alu_exec) begin
            nexec++;
            if (alu_opcode !== op || alu_operand_A !== a || alu_operand_B !== b) stable = 1'b0;
         end
      end
      hi = bif.z_hi; lo = bif.z_lo; err = bif.rsp_err;
      @(negedge clk);
      pulse1 = !bif.rsp_valid;
   endtask

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a, b, hi, lo;
      int          w;
   } vec_t;

   vec_t vecs[13];

   initial begin
      logic [31:0] hi, lo;
      logic        err, stable, pulse1, seen;
      int          nexec, lat;

      vecs[0]  = '{"add",  4'd0,  32'd5,          32'd7,          32'h0,        32'd12,       1};
      vecs[1]  = '{"sub",  4'd1,  32'd5,          32'd7,          32'h0,        32'hFFFFFFFE, 1};
      vecs[2]  = '{"and",  4'd2,  32'hF0F0F0F0,   32'hFF00FF00,   32'h0,        32'hF000F000, 1};
      vecs[3]  = '{"or",   4'd3,  32'h0F0F0000,   32'h000000FF,   32'h0,        32'h0F0F00FF, 1};
      vecs[4]  = '{"neg",  4'd4,  32'd1,          32'd0,          32'h0,        32'hFFFFFFFF, 1};
      vecs[5]  = '{"not",  4'd5,  32'h12345678,   32'd0,          32'h0,        32'hEDCBA987, 1};
      vecs[6]  = '{"shr",  4'd6,  32'h80000000,   32'd4,          32'h0,        32'h08000000, 1};
      vecs[7]  = '{"shra", 4'd7,  32'h80000000,   32'd4,          32'h0,        32'hF8000000, 1};
      vecs[8]  = '{"shl",  4'd8,  32'd1,          32'd31,         32'h0,        32'h80000000, 1};
      vecs[9]  = '{"ror",  4'd9,  32'd1,          32'd1,          32'h0,        32'h80000000, 1};
      vecs[10] = '{"rol",  4'd10, 32'h80000000,   32'd1,          32'h0,        32'h00000001, 1};
      vecs[11] = '{"mul",  4'd11, 32'hFFFFFFFF,   32'd2,          32'hFFFFFFFF, 32'hFFFFFFFE, 4};
      vecs[12] = '{"div",  4'd12, 32'd100,        32'd7,          32'd2,        32'd14,       4};

      bif.req_valid = 1'b0; bif.req_op = '0; bif.req_a = '0; bif.req_b = '0;
      bif.rsp_ready = 1'b1;
      clear = 1'b1;
      repeat (2) @(posedge clk);
      #1 clear = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 64'(bif.req_ready), 64'd1);
      chk("rst_rsp_valid", 64'(bif.rsp_valid), 64'd0);
      chk("rst_exec",      64'(alu_exec),      64'd0);
      chk("rst_z",         {bif.z_hi, bif.z_lo}, 64'd0);
      chk("rst_err",       64'(bif.rsp_err),   64'd0);
      chk("rst_busy",      64'(busy),          64'd0);
      chk("rst_alu_in",    {28'd0, alu_opcode, alu_operand_A}, 64'd0);

      for (int i = 0; i < 13; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, err, nexec, lat, stable, pulse1);
         chk({vecs[i].name, "_z"},      {hi, lo}, {vecs[i].hi, vecs[i].lo});
         chk({vecs[i].name, "_err"},    64'(err), 64'd0);
         chk({vecs[i].name, "_nexec"},  64'(nexec), 64'(vecs[i].w));
         chk({vecs[i].name, "_lat"},    64'(lat), 64'(vecs[i].w + 1));
         chk({vecs[i].name, "_stable"}, 64'(stable), 64'd1);
         chk({vecs[i].name, "_pulse"},  64'(pulse1), 64'd1);
      end

      // backpressure: response held, second request ignored until one IDLE cycle after handshake
      bif.rsp_ready = 1'b0;
      @(negedge clk);
      bif.req_valid = 1'b1; bif.req_op = 4'd2; bif.req_a = 32'hF0F0F0F0; bif.req_b = 32'hFF00FF00;
      @(posedge clk); #1;
      bif.req_op = 4'd0; bif.req_a = 32'd1; bif.req_b = 32'd2;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (bif.rsp_valid) begin lat = c; break; end
      end
      chk("bp_lat", 64'(lat), 64'd2);
      for (int c = 0; c < 5; c++) begin
         chk("bp_hold_valid", 64'(bif.rsp_valid), 64'd1);
         chk("bp_hold_z",     {bif.z_hi, bif.z_lo}, {32'h0, 32'hF000F000});
         chk("bp_ready_low",  {62'd0, bif.req_ready, alu_exec}, 64'd0);
         @(negedge clk);
      end
      bif.rsp_ready = 1'b1;
      @(negedge clk);
      bif.rsp_ready = 1'b0;
      chk("bp_idle_gap",   {61'd0, bif.rsp_valid, bif.req_ready, alu_exec}, 64'b010);
      chk("bp_z_retained", 64'(bif.z_lo), 64'hF000F000);
      @(posedge clk); #1 bif.req_valid = 1'b0;
      @(negedge clk);
      chk("bp_second_exec", {59'd0, alu_exec, alu_opcode}, {59'd0, 1'b1, 4'd0});
      bif.rsp_ready = 1'b1;
      lat = -1;
      for (int c = 1; c <= 20; c++) begin
         if (bif.rsp_valid) begin lat = c; break; end
         @(negedge clk);
      end
      chk("bp_second_lat", 64'(lat), 64'd2);
      chk("bp_second_z",   64'(bif.z_lo), 64'd3);
      @(negedge clk);

      // clear in the 2nd EXEC cycle of a MUL abandons the operation
      @(negedge clk);
      bif.req_valid = 1'b1; bif.req_op = 4'd11; bif.req_a = 32'd3; bif.req_b = 32'd3;
      @(posedge clk); #1 bif.req_valid = 1'b0;
      @(negedge clk);
      chk("clr_exec1", 64'(alu_exec), 64'd1);
      @(negedge clk);
      chk("clr_exec2", 64'(alu_exec), 64'd1);
      clear = 1'b1;
      @(posedge clk); #1 clear = 1'b0;
      @(negedge clk);
      chk("clr_exec_low", 64'(alu_exec), 64'd0);
      chk("clr_z",        {bif.z_hi, bif.z_lo}, 64'd0);
      chk("clr_ready",    64'(bif.req_ready), 64'd1);
      chk("clr_busy",     64'(busy), 64'd0);
      seen = 1'b0;
      for (int c = 0; c < 8; c++) begin
         if (bif.rsp_valid) seen = 1'b1;
         @(negedge clk);
      end
      chk("clr_no_rsp", 64'(seen), 64'd0);

      // illegal opcode 14
      run_op(4'd14, 32'h0000DEAD, 32'h0000BEEF, hi, lo, err, nexec, lat, stable, pulse1);
`ifdef ALU_ISSUE_OPCHECK_EN
      chk("ill_nexec", 64'(nexec), 64'd0);
      chk("ill_lat",   64'(lat), 64'd1);
      chk("ill_err",   64'(err), 64'd1);
      chk("ill_z",     {hi, lo}, 64'd0);
      run_op(4'd0, 32'd5, 32'd7, hi, lo, err, nexec, lat, stable, pulse1);
      chk("ill_add_err", 64'(err), 64'd0);
      chk("ill_add_z",   {hi, lo}, 64'd12);
`else
      chk("ill_nexec", 64'(nexec), 64'd1);
      chk("ill_lat",   64'(lat), 64'd2);
      chk("ill_err",   64'(err), 64'd0);
      chk("ill_z",     {hi, lo}, {32'h0000DEAD, 32'h0000BEEF});
`endif

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end
endmodule
